// File: rtl/asm_parse_pkg.sv
// Shared definitions for the assembly-source line classifier:
// parser states and character classes.
`default_nettype none

package asm_parse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEAD = 2'd1,
    ST_WORD = 2'd2,
    ST_REST = 2'd3
  } parse_state_t;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_UNDER = 8'h5F;
  localparam logic [7:0] CH_LC_A  = 8'h61;
  localparam logic [7:0] CH_LC_Z  = 8'h7A;
  localparam logic [7:0] CH_UC_A  = 8'h41;
  localparam logic [7:0] CH_UC_Z  = 8'h5A;

  function automatic logic is_space(input logic [7:0] c);
    return (c == CH_SPACE) || (c == CH_TAB);
  endfunction

  function automatic logic is_word_start(input logic [7:0] c);
    return ((c >= CH_LC_A) && (c <= CH_LC_Z)) ||
           ((c >= CH_UC_A) && (c <= CH_UC_Z)) ||
           (c == CH_UNDER);
  endfunction

endpackage

`default_nettype wire

// File: rtl/line_pc_ram.sv
// Simple dual-port line table: one write port, one registered read port.
`default_nettype none

module line_pc_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Read returns the old contents when the same address is written this cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/line_pc_table.sv
// Streams assembly source characters, classifies each line as instruction or
// not, and records the PC assigned to every line for 1-cycle lookups.
`default_nettype none

module line_pc_table
  import asm_parse_pkg::*;
#(
  parameter  int NUMBER_LINES = 256,
  parameter  int PC_STEP      = 4,
  parameter  int BASE_PC      = 0,
  localparam int LW           = $clog2(NUMBER_LINES),
  localparam int PW           = $clog2(NUMBER_LINES * PC_STEP) + 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          new_line,
  input  logic          new_character,
  input  logic [7:0]    incoming_ascii,
  input  logic          eof_in,
  input  logic          lookup_valid_in,
  input  logic [LW-1:0] lookup_line_in,
  output logic          lookup_valid_out,
  output logic          lookup_hit_out,
  output logic          lookup_is_instr_out,
  output logic [PW-1:0] lookup_pc_out,
  output logic [PW-1:0] pc_out,
  output logic [LW:0]   line_count_out,
  output logic [LW:0]   instr_count_out,
  output logic          overflow_out
);

  localparam logic [LW:0]   FULL_COUNT = (LW + 1)'(NUMBER_LINES);
  localparam logic [LW:0]   COUNT_ONE  = (LW + 1)'(1);
  localparam logic [PW-1:0] STEP       = PW'(PC_STEP);
  localparam logic [PW-1:0] PC_RESET   = PW'(BASE_PC);

  parse_state_t state, next_state, line_state;
  logic         cand, next_cand, line_cand;
  logic         commit;
  logic         full;
  logic         wr_en;
  logic [PW:0]  wr_data;
  logic [PW:0]  rd_data;
  logic         hit_q;
  logic [PW-1:0] pc;
  logic [LW:0]   line_count;
  logic [LW:0]   instr_count;
  logic          overflow;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= ST_IDLE;
      cand  <= 1'b0;
    end else begin
      state <= next_state;
      cand  <= next_cand;
    end
  end

  // A line boundary is resolved first; a coincident character then belongs
  // to the freshly opened line.
  always_comb begin
    commit     = (state != ST_IDLE) && (new_line || eof_in);
    line_state = state;
    line_cand  = cand;
    if (eof_in && (state != ST_IDLE)) begin
      line_state = ST_IDLE;
      line_cand  = 1'b0;
    end else if (new_line) begin
      line_state = ST_LEAD;
      line_cand  = 1'b0;
    end

    next_state = line_state;
    next_cand  = line_cand;
    if (new_character) begin
      unique case (line_state)
        ST_LEAD: begin
          if (is_word_start(incoming_ascii)) begin
            next_state = ST_WORD;
            next_cand  = 1'b1;
          end else if (!is_space(incoming_ascii)) begin
            next_state = ST_REST;
            next_cand  = 1'b0;
          end
        end
        ST_WORD: begin
          if (incoming_ascii == CH_COLON) begin
            next_state = ST_REST;
            next_cand  = 1'b0;
          end else if (is_space(incoming_ascii)) begin
            next_state = ST_REST;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    full    = (line_count == FULL_COUNT);
    wr_en   = commit && !full;
    wr_data = {cand, pc};
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pc          <= PC_RESET;
      line_count  <= '0;
      instr_count <= '0;
      overflow    <= 1'b0;
    end else if (commit) begin
      if (full) begin
        overflow <= 1'b1;
      end else begin
        line_count <= line_count + COUNT_ONE;
        if (cand) begin
          pc          <= pc + STEP;
          instr_count <= instr_count + COUNT_ONE;
        end
      end
    end
  end

  line_pc_ram #(
    .DEPTH (NUMBER_LINES),
    .AW    (LW),
    .DW    (PW + 1)
  ) u_ram (
    .clk     (clk_in),
    .wr_en   (wr_en),
    .wr_addr (line_count[LW-1:0]),
    .wr_data (wr_data),
    .rd_addr (lookup_line_in),
    .rd_data (rd_data)
  );

  // Hit is decided against the count before any same-cycle commit lands.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      lookup_valid_out <= 1'b0;
      hit_q            <= 1'b0;
    end else begin
      lookup_valid_out <= lookup_valid_in;
      hit_q            <= lookup_valid_in && ({1'b0, lookup_line_in} < line_count);
    end
  end

  assign lookup_hit_out      = hit_q;
  assign lookup_is_instr_out = hit_q & rd_data[PW];
  assign lookup_pc_out       = hit_q ? rd_data[PW-1:0] : '0;
  assign pc_out              = pc;
  assign line_count_out      = line_count;
  assign instr_count_out     = instr_count;
  assign overflow_out        = overflow;

endmodule

`default_nettype wire

// File: tb/tb_line_pc_table.sv
// Bench for line_pc_table: default, 4-line and offset-PC instances share one
// character stream; lookups are checked through an expected-result queue.
`default_nettype none

module tb_line_pc_table;

  localparam int D_LW = 8;
  localparam int D_PW = 11;
  localparam int S_LW = 2;
  localparam int S_PW = 5;
  localparam int B_LW = 8;
  localparam int B_PW = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_line = 1'b0;
  logic       new_character = 1'b0;
  logic [7:0] incoming_ascii = 8'h00;
  logic       eof_in = 1'b0;
  logic       lookup_valid = 1'b0;
  logic [7:0] lookup_line = 8'h00;

  logic            d_lv, d_hit, d_instr, d_ov;
  logic [D_PW-1:0] d_lpc, d_pc;
  logic [D_LW:0]   d_lc, d_ic;
  logic            s_lv, s_hit, s_instr, s_ov;
  logic [S_PW-1:0] s_lpc, s_pc;
  logic [S_LW:0]   s_lc, s_ic;
  logic            b_lv, b_hit, b_instr, b_ov;
  logic [B_PW-1:0] b_lpc, b_pc;
  logic [B_LW:0]   b_lc, b_ic;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_pc_table dut_d (
    .clk_in(clk), .rst_in(rst_n), .new_line(new_line), .new_character(new_character),
    .incoming_ascii(incoming_ascii), .eof_in(eof_in), .lookup_valid_in(lookup_valid),
    .lookup_line_in(lookup_line), .lookup_valid_out(d_lv), .lookup_hit_out(d_hit),
    .lookup_is_instr_out(d_instr), .lookup_pc_out(d_lpc), .pc_out(d_pc),
    .line_count_out(d_lc), .instr_count_out(d_ic), .overflow_out(d_ov));

  line_pc_table #(.NUMBER_LINES(4)) dut_s (
    .clk_in(clk), .rst_in(rst_n), .new_line(new_line), .new_character(new_character),
    .incoming_ascii(incoming_ascii), .eof_in(eof_in), .lookup_valid_in(lookup_valid),
    .lookup_line_in(lookup_line[S_LW-1:0]), .lookup_valid_out(s_lv), .lookup_hit_out(s_hit),
    .lookup_is_instr_out(s_instr), .lookup_pc_out(s_lpc), .pc_out(s_pc),
    .line_count_out(s_lc), .instr_count_out(s_ic), .overflow_out(s_ov));

  line_pc_table #(.PC_STEP(2), .BASE_PC(32'h100)) dut_b (
    .clk_in(clk), .rst_in(rst_n), .new_line(new_line), .new_character(new_character),
    .incoming_ascii(incoming_ascii), .eof_in(eof_in), .lookup_valid_in(lookup_valid),
    .lookup_line_in(lookup_line), .lookup_valid_out(b_lv), .lookup_hit_out(b_hit),
    .lookup_is_instr_out(b_instr), .lookup_pc_out(b_lpc), .pc_out(b_pc),
    .line_count_out(b_lc), .instr_count_out(b_ic), .overflow_out(b_ov));

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  typedef struct {
    int sel;
    bit hit;
    bit instr;
    int pc;
    int cyc;
  } exp_t;
  exp_t sb[$];

  // Lookup scoreboard: sel picks which instance the entry describes.
  always @(negedge clk) begin
    if (rst_n && (d_lv || s_lv || b_lv)) begin
      if (sb.size() == 0) begin
        chk("lookup_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        logic v, h, i;
        logic [31:0] p;
        e = sb.pop_front();
        case (e.sel)
          1:       begin v = s_lv; h = s_hit; i = s_instr; p = 32'(s_lpc); end
          2:       begin v = b_lv; h = b_hit; i = b_instr; p = 32'(b_lpc); end
          default: begin v = d_lv; h = d_hit; i = d_instr; p = 32'(d_lpc); end
        endcase
        chk("lookup_latency", cyc - e.cyc, 1);
        chk("lookup_valid", 32'(v), 1);
        chk("lookup_hit", 32'(h), 32'(e.hit));
        chk("lookup_instr", 32'(i), 32'(e.instr));
        chk("lookup_pc", p, e.pc);
      end
    end
  end

  task automatic do_lookup(input int sel, input int idx, input bit hit, input bit instr, input int pc);
    exp_t e;
    @(negedge clk);
    lookup_valid = 1'b1;
    lookup_line  = 8'(idx);
    e.sel = sel; e.hit = hit; e.instr = hit ? instr : 1'b0; e.pc = hit ? pc : 0; e.cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    lookup_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("lookup_drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic send_chars(input string s);
    for (int i = 0; i < s.len(); i++) begin
      new_character  = 1'b1;
      incoming_ascii = s[i];
      @(negedge clk);
    end
    new_character = 1'b0;
  endtask

  task automatic send_line(input string s);
    @(negedge clk);
    new_line = 1'b1;
    @(negedge clk);
    new_line = 1'b0;
    send_chars(s);
  endtask

  task automatic send_eof();
    @(negedge clk);
    eof_in = 1'b1;
    @(negedge clk);
    eof_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    new_line = 1'b0; new_character = 1'b0; eof_in = 1'b0; lookup_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    string text;
    bit    instr;
    int    pc;
  } line_vec_t;
  line_vec_t vec[13];

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0]  = '{"add x1,x2,x3", 1'b1, 0};
    vec[1]  = '{"# c",          1'b0, 4};
    vec[2]  = '{"loop:",        1'b0, 4};
    vec[3]  = '{"  sub x1",     1'b1, 4};
    vec[4]  = '{"_x y",         1'b1, 8};
    vec[5]  = '{"  ",           1'b0, 12};
    vec[6]  = '{".data",        1'b0, 12};
    vec[7]  = '{"9a",           1'b0, 12};
    vec[8]  = '{"ab:c",         1'b0, 12};
    vec[9]  = '{"mv\tx",        1'b1, 12};
    vec[10] = '{"loop",         1'b1, 16};
    vec[11] = '{"\t\tret",      1'b1, 20};
    vec[12] = '{"",             1'b0, 24};

    // Reset values while reset is held.
    #12;
    chk("rst_pc", 32'(d_pc), 0);
    chk("rst_line_count", 32'(d_lc), 0);
    chk("rst_instr_count", 32'(d_ic), 0);
    chk("rst_overflow", 32'(d_ov), 0);
    chk("rst_lookup_valid", 32'(d_lv), 0);
    chk("rst_lookup_hit", 32'(d_hit), 0);
    chk("rst_lookup_instr", 32'(d_instr), 0);
    chk("rst_lookup_pc", 32'(d_lpc), 0);
    chk("rst_base_pc", 32'(b_pc), 32'h100);
    do_reset();

    // Four-line program then eof.
    for (int i = 0; i < 4; i++) send_line(vec[i].text);
    send_eof();
    chk("a_line_count", 32'(d_lc), 4);
    chk("a_instr_count", 32'(d_ic), 2);
    chk("a_pc", 32'(d_pc), 8);
    for (int i = 0; i < 4; i++) do_lookup(0, i, 1'b1, vec[i].instr, vec[i].pc);
    do_lookup(0, 4, 1'b0, 1'b0, 0);
    drain();

    // More line shapes appended after the eof.
    for (int i = 4; i < 13; i++) send_line(vec[i].text);
    send_eof();
    chk("b_line_count", 32'(d_lc), 13);
    chk("b_instr_count", 32'(d_ic), 6);
    chk("b_pc", 32'(d_pc), 24);
    chk("b_overflow", 32'(d_ov), 0);
    chk("b_small_line_count", 32'(s_lc), 4);
    chk("b_small_overflow", 32'(s_ov), 1);
    chk("b_small_pc", 32'(s_pc), 8);
    for (int i = 0; i < 13; i++) do_lookup(0, i, 1'b1, vec[i].instr, vec[i].pc);
    do_lookup(0, 13, 1'b0, 1'b0, 0);
    do_lookup(0, 255, 1'b0, 1'b0, 0);
    drain();

    // Offset PC / small-table overflow.
    do_reset();
    for (int i = 0; i < 3; i++) send_line("nop");
    send_eof();
    chk("c_base_pc", 32'(b_pc), 32'h106);
    chk("c_base_instr_count", 32'(b_ic), 3);
    chk("c_small_line_count", 32'(s_lc), 3);
    chk("c_small_overflow_early", 32'(s_ov), 0);
    for (int i = 0; i < 3; i++) do_lookup(2, i, 1'b1, 1'b1, 32'h100 + 2 * i);
    do_lookup(2, 3, 1'b0, 1'b0, 0);
    drain();
    for (int i = 0; i < 3; i++) send_line("nop");
    send_eof();
    chk("c_small_line_count_full", 32'(s_lc), 4);
    chk("c_small_instr_count", 32'(s_ic), 4);
    chk("c_small_overflow", 32'(s_ov), 1);
    chk("c_small_pc", 32'(s_pc), 16);
    chk("c_default_pc", 32'(d_pc), 24);
    chk("c_default_line_count", 32'(d_lc), 6);
    do_lookup(1, 3, 1'b1, 1'b1, 12);
    drain();

    // New line coincident with a character.
    do_reset();
    send_line("#");
    @(negedge clk);
    new_line = 1'b1; new_character = 1'b1; incoming_ascii = 8'h61;
    @(negedge clk);
    new_line = 1'b0;
    send_chars("dd x");
    send_eof();
    chk("d_line_count", 32'(d_lc), 2);
    chk("d_instr_count", 32'(d_ic), 1);
    chk("d_pc", 32'(d_pc), 4);
    do_lookup(0, 0, 1'b1, 1'b0, 0);
    do_lookup(0, 1, 1'b1, 1'b1, 0);
    drain();

    // Reset in the middle of a word on the third line.
    do_reset();
    send_line("nop");
    send_line("nop");
    @(negedge clk);
    new_line = 1'b1;
    @(negedge clk);
    new_line = 1'b0;
    send_chars("ad");
    chk("e_line_count_pre", 32'(d_lc), 2);
    rst_n = 1'b0;
    #1;
    chk("e_rst_pc", 32'(d_pc), 0);
    chk("e_rst_line_count", 32'(d_lc), 0);
    chk("e_rst_instr_count", 32'(d_ic), 0);
    chk("e_rst_overflow", 32'(d_ov), 0);
    chk("e_rst_lookup_hit", 32'(d_hit), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_eof();
    chk("e_eof_idle_line_count", 32'(d_lc), 0);
    do_lookup(0, 0, 1'b0, 1'b0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
